// File: rtl/trig_phase_lock.sv
// rtl/trig_phase_lock.sv - trigger phase calibration, re-timing into hold windows, hit histograms
// Trigger-count histograms are built only when TRIG_PHASE_HIST_EN is defined.
module trig_phase_lock #(
    parameter int NCH      = 16,
    parameter int NBINS    = 4,
    parameter int CNTW     = 6,
    parameter int LOCK_MIN = 50,
    parameter int SETTLE   = 200,
    parameter int MEAS     = 455,
    parameter int HOLD     = 12,
    parameter int HISTW    = 32,
    localparam int PW      = $clog2(NBINS),
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk_adc,
    input  logic                  rst,
    input  logic [NCH-1:0]        coax_in,
    input  logic                  cal_start,
    input  logic                  hist_clr,
    input  logic [CHW-1:0]        hist_ch,
    input  logic [PW:0]           hist_sel,
    output logic [HISTW-1:0]      hist_data,
    output logic                  cal_busy,
    output logic [NCH-1:0]        lock,
    output logic [NCH-1:0]        cal_err,
    output logic [NCH*PW-1:0]     phase,
    output logic [NCH*NBINS-1:0]  trig_bin
);
    localparam int CYCMAX = (SETTLE > MEAS) ? SETTLE : MEAS;
    localparam int CYCW   = $clog2(CYCMAX + 1);
    localparam int HW     = $clog2(HOLD + 1);

    typedef enum logic [1:0] {S_RUN, S_SETTLE, S_MEAS, S_EVAL} state_t;

    state_t              state, state_n;
    logic [CYCW-1:0]     cyc;
    logic [NCH-1:0]      coax_q;
    logic [PW-1:0]       phase_ctr;
    logic [CNTW-1:0]     rec  [NBINS][NCH];
    logic [HW-1:0]       hold [NBINS][NCH];
    logic [NCH-1:0]      hit;
    logic [PW-1:0]       hbin [NCH];
    logic [NBINS-1:0]    nzm  [NCH];
    logic [NBINS-1:0]    gem  [NCH];
    logic [PW-1:0]       ev_bin [NCH];
    logic [NCH-1:0]      ev_ok;
    logic [HISTW-1:0]    rd_val;

    always_ff @(posedge clk_adc) begin
        if (rst) state <= S_RUN;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_RUN:    if (cal_start) state_n = S_SETTLE;
            S_SETTLE: if (cyc == CYCW'(SETTLE - 1)) state_n = S_MEAS;
            S_MEAS:   if (cyc == CYCW'(MEAS - 1)) state_n = S_EVAL;
            S_EVAL:   state_n = S_RUN;
            default:  state_n = S_RUN;
        endcase
    end

    assign cal_busy = (state != S_RUN);

    always_ff @(posedge clk_adc) begin
        if (rst || state != state_n) cyc <= '0;
        else if (cal_busy)           cyc <= cyc + 1'b1;
    end

    // A channel locks only if exactly one bin saw hits and that bin reached LOCK_MIN.
    always_comb begin
        for (int j = 0; j < NCH; j++) begin
            ev_bin[j] = '0;
            nzm[j]    = '0;
            gem[j]    = '0;
            for (int b = 0; b < NBINS; b++) begin
                nzm[j][b] = (rec[b][j] != '0);
                gem[j][b] = (32'(rec[b][j]) >= LOCK_MIN);
                if (nzm[j][b]) ev_bin[j] = PW'(b);
            end
            ev_ok[j] = $onehot(nzm[j]) && (|gem[j]);
        end
    end

    always_comb begin
        for (int j = 0; j < NCH; j++) begin
            hit[j]  = (state == S_RUN) && lock[j] && coax_q[j];
            hbin[j] = phase_ctr - phase[j*PW +: PW];
        end
    end

    always_ff @(posedge clk_adc) begin
        if (rst) begin
            coax_q    <= '0;
            phase_ctr <= '0;
            lock      <= '0;
            cal_err   <= '0;
            phase     <= '0;
            for (int b = 0; b < NBINS; b++)
                for (int j = 0; j < NCH; j++) begin
                    rec[b][j]  <= '0;
                    hold[b][j] <= '0;
                end
        end else begin
            coax_q    <= coax_in;
            phase_ctr <= phase_ctr + 1'b1;
            for (int b = 0; b < NBINS; b++)
                for (int j = 0; j < NCH; j++) begin
                    if (state == S_RUN && cal_start)
                        rec[b][j] <= '0;
                    else if (state == S_MEAS && coax_q[j] && phase_ctr == PW'(b) && rec[b][j] != '1)
                        rec[b][j] <= rec[b][j] + 1'b1;

                    if (state != S_RUN || cal_start)
                        hold[b][j] <= '0;
                    else if (hit[j] && hbin[j] == PW'(b))
                        hold[b][j] <= HW'(HOLD);
                    else if (hold[b][j] != '0)
                        hold[b][j] <= hold[b][j] - 1'b1;
                end
            if (state == S_EVAL) begin
                lock    <= ev_ok;
                cal_err <= ~ev_ok;
                for (int j = 0; j < NCH; j++)
                    phase[j*PW +: PW] <= ev_ok[j] ? ev_bin[j] : '0;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NCH; j++)
            for (int b = 0; b < NBINS; b++)
                trig_bin[j*NBINS + b] = (hold[b][j] != '0);
    end

`ifdef TRIG_PHASE_HIST_EN
    logic [HISTW-1:0] cnt [NBINS][NCH];

    // Clear has priority so a hit landing on the clear cycle is discarded.
    always_ff @(posedge clk_adc) begin
        for (int b = 0; b < NBINS; b++)
            for (int j = 0; j < NCH; j++) begin
                if (rst || hist_clr)
                    cnt[b][j] <= '0;
                else if (hit[j] && hbin[j] == PW'(b) && cnt[b][j] != '1)
                    cnt[b][j] <= cnt[b][j] + 1'b1;
            end
    end
`else
    logic unused_hist_clr;
    assign unused_hist_clr = hist_clr;
`endif

    always_comb begin
        rd_val = '0;
        if (32'(hist_ch) < NCH) begin
            if (!hist_sel[PW])
                rd_val = HISTW'(rec[hist_sel[PW-1:0]][hist_ch]);
`ifdef TRIG_PHASE_HIST_EN
            else
                rd_val = cnt[hist_sel[PW-1:0]][hist_ch];
`endif
        end
    end

    always_ff @(posedge clk_adc) begin
        if (rst) hist_data <= '0;
        else     hist_data <= rd_val;
    end
endmodule

// File: tb/tb_trig_phase_lock.sv
// tb/tb_trig_phase_lock.sv - self-checking bench for trig_phase_lock
module tb_trig_phase_lock;
    logic        clk_adc = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] coax_in = '0;
    logic        cal_start = 1'b0;
    logic        hist_clr = 1'b0;
    logic [3:0]  hist_ch = '0;
    logic [2:0]  hist_sel = '0;
    logic [31:0] hist_data;
    logic        cal_busy;
    logic [15:0] lock;
    logic [15:0] cal_err;
    logic [31:0] phase;
    logic [63:0] trig_bin;

`ifdef TRIG_PHASE_HIST_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    trig_phase_lock dut (
        .clk_adc   (clk_adc),
        .rst       (rst),
        .coax_in   (coax_in),
        .cal_start (cal_start),
        .hist_clr  (hist_clr),
        .hist_ch   (hist_ch),
        .hist_sel  (hist_sel),
        .hist_data (hist_data),
        .cal_busy  (cal_busy),
        .lock      (lock),
        .cal_err   (cal_err),
        .phase     (phase),
        .trig_bin  (trig_bin)
    );

    always #5 clk_adc = ~clk_adc;

    // Free-running phase model: value during the current cycle.
    logic [1:0] m_phase = '0;
    always @(posedge clk_adc) m_phase <= rst ? 2'd0 : m_phase + 2'd1;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic [3:0]  ch;
        logic [2:0]  sel;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    rd_vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic readback(input logic [3:0] ch, input logic [2:0] sel,
                            input logic [31:0] exp, input string name);
        @(negedge clk_adc);
        hist_ch  = ch;
        hist_sel = sel;
        exp_q.push_back(exp);
        @(negedge clk_adc);
        check(name, {32'd0, hist_data}, {32'd0, exp_q.pop_front()});
    endtask

    task automatic wait_phase(input logic [1:0] p);
        for (int i = 0; i < 8 && m_phase != p; i++) @(negedge clk_adc);
    endtask

    // Drives a full calibration; ch3 fires when m_phase==p3 (coax_q one phase later).
    task automatic run_cal(input logic [1:0] p3, input bit with5, input string name);
        int dur;
        dur = -1;
        @(negedge clk_adc);
        cal_start = 1'b1;
        @(negedge clk_adc);
        cal_start = 1'b0;
        check({name, " busy_rise"}, {63'd0, cal_busy}, 64'd1);
        for (int c = 0; c < 700; c++) begin
            coax_in = '0;
            if (c < 650 && m_phase == p3) coax_in[3] = 1'b1;
            if (with5 && c + 1 >= 300 && c + 1 < 380 && (m_phase == 2'd0 || m_phase == 2'd2))
                coax_in[5] = 1'b1;
            @(negedge clk_adc);
            if (!cal_busy) begin
                dur = c + 1;
                break;
            end
        end
        coax_in = '0;
        check({name, " duration"}, 64'(dur), 64'd656);
    endtask

    // Observes trig_bin for n cycles after a hit driven in cycle 0.
    task automatic watch(input int from, input int to, input int n, input logic [63:0] mask,
                         input int rehit, input int clr_k, input string name);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk_adc);
            coax_in  = '0;
            hist_clr = (k == clr_k);
            check(name, trig_bin, (k >= from && k <= to) ? mask : 64'd0);
            if (k == rehit) coax_in[3] = 1'b1;
        end
        coax_in  = '0;
        hist_clr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'd3, 3'd2, 32'd63, "rec_b2_ch3"};
        vecs[1] = '{4'd3, 3'd0, 32'd0,  "rec_b0_ch3"};
        vecs[2] = '{4'd3, 3'd1, 32'd0,  "rec_b1_ch3"};
        vecs[3] = '{4'd3, 3'd3, 32'd0,  "rec_b3_ch3"};
        vecs[4] = '{4'd5, 3'd1, 32'd20, "rec_b1_ch5"};
        vecs[5] = '{4'd5, 3'd3, 32'd20, "rec_b3_ch5"};
        vecs[6] = '{4'd5, 3'd0, 32'd0,  "rec_b0_ch5"};
        vecs[7] = '{4'd0, 3'd2, 32'd0,  "rec_b2_ch0"};
        vecs[8] = '{4'd3, 3'd4, 32'd0,  "cnt_b0_ch3"};
        vecs[9] = '{4'd3, 3'd5, 32'd0,  "cnt_b1_ch3"};

        repeat (3) @(negedge clk_adc);
        rst = 1'b0;
        @(negedge clk_adc);
        check("rst lock", {48'd0, lock}, 64'd0);
        check("rst cal_err", {48'd0, cal_err}, 64'd0);
        check("rst phase", {32'd0, phase}, 64'd0);
        check("rst trig_bin", trig_bin, 64'd0);
        check("rst cal_busy", {63'd0, cal_busy}, 64'd0);
        check("rst hist_data", {32'd0, hist_data}, 64'd0);

        run_cal(2'd1, 1'b1, "cal1");
        check("cal1 lock", {48'd0, lock}, 64'h0008);
        check("cal1 cal_err", {48'd0, cal_err}, 64'hfff7);
        check("cal1 phase", {32'd0, phase}, 64'h80);
        check("cal1 trig_bin", trig_bin, 64'd0);

        foreach (vecs[i]) readback(vecs[i].ch, vecs[i].sel, vecs[i].exp, vecs[i].name);

        wait_phase(2'd2);
        coax_in[3] = 1'b1;
        watch(2, 13, 16, 64'd1 << 13, 0, 0, "single_hit");
        readback(4'd3, 3'd5, HIST ? 32'd1 : 32'd0, "cnt_b1_ch3_single");
        readback(4'd3, 3'd6, 32'd0, "cnt_b2_ch3_single");

        coax_in[5] = 1'b1;
        watch(99, 99, 16, 64'd0, 0, 0, "unlocked_hit");
        readback(4'd5, 3'd5, 32'd0, "cnt_b1_ch5");

        wait_phase(2'd2);
        coax_in[3] = 1'b1;
        watch(2, 21, 24, 64'd1 << 13, 8, 0, "rehit");
        readback(4'd3, 3'd5, HIST ? 32'd3 : 32'd0, "cnt_b1_ch3_rehit");

        wait_phase(2'd2);
        coax_in[3] = 1'b1;
        watch(2, 13, 15, 64'd1 << 13, 0, 1, "clr_hit");
        readback(4'd3, 3'd5, 32'd0, "cnt_b1_ch3_clr");

        @(negedge clk_adc);
        cal_start = 1'b1;
        @(negedge clk_adc);
        cal_start = 1'b0;
        repeat (299) @(negedge clk_adc);
        rst = 1'b1;
        @(negedge clk_adc);
        rst = 1'b0;
        check("abort cal_busy", {63'd0, cal_busy}, 64'd0);
        check("abort lock", {48'd0, lock}, 64'd0);
        check("abort cal_err", {48'd0, cal_err}, 64'd0);
        readback(4'd3, 3'd2, 32'd0, "abort rec_b2_ch3");

        run_cal(2'd0, 1'b0, "cal2");
        check("cal2 lock", {48'd0, lock}, 64'h0008);
        check("cal2 cal_err", {48'd0, cal_err}, 64'hfff7);
        check("cal2 phase", {32'd0, phase}, 64'h40);
        readback(4'd3, 3'd1, 32'd63, "cal2 rec_b1_ch3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
